// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one byte-wide RAM port between instruction fetch and the
// memory stage, serialising 32-bit fetches and byte/half/word accesses.
// Optional build macro MEM_ARB_IBUF_EN adds a one-entry fetch buffer.
module mem_arbiter #(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic              if_done,
  output logic [31:0]       if_inst,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [1:0]        mem_len,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_wdata,
  output logic              mem_done,
  output logic [31:0]       mem_rdata,
  input  logic [7:0]        ram_din,
  output logic [7:0]        ram_dout,
  output logic [ADDR_W-1:0] ram_a,
  output logic              ram_wr,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, IF_RD, MEM_RD, MEM_WR} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [2:0]        nbytes_q, nbytes_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       asm_q, asm_d;
  logic [31:0]       if_inst_q, if_inst_d;
  logic [31:0]       mem_rdata_q, mem_rdata_d;
  logic              if_done_q, if_done_d;
  logic              mem_done_q, mem_done_d;
  logic [ADDR_W-1:0] ram_a_q, ram_a_d;
  logic [7:0]        ram_dout_q, ram_dout_d;
  logic              ram_wr_q, ram_wr_d;
  logic [2:0]        nxt;
  logic [1:0]        cap_idx;
`ifdef MEM_ARB_IBUF_EN
  logic              ib_valid_q, ib_valid_d;
  logic [ADDR_W-1:0] ib_tag_q, ib_tag_d;
  logic [31:0]       ib_word_q, ib_word_d;
`endif

  // Next-state, RAM port sequencing and result assembly.
  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    nbytes_d    = nbytes_q;
    cnt_d       = cnt_q;
    wdata_d     = wdata_q;
    asm_d       = asm_q;
    if_inst_d   = if_inst_q;
    mem_rdata_d = mem_rdata_q;
    ram_a_d     = ram_a_q;
    ram_dout_d  = ram_dout_q;
    if_done_d   = 1'b0;
    mem_done_d  = 1'b0;
    ram_wr_d    = 1'b0;
    nxt         = cnt_q + 3'd1;
    // Read data trails the address by one cycle, so step cnt captures byte cnt-1.
    cap_idx     = cnt_q[1:0] - 2'd1;
`ifdef MEM_ARB_IBUF_EN
    ib_valid_d  = ib_valid_q;
    ib_tag_d    = ib_tag_q;
    ib_word_d   = ib_word_q;
`endif
    case (state_q)
      IDLE: begin
        if (mem_req) begin
          base_d  = mem_addr;
          ram_a_d = mem_addr;
          wdata_d = mem_wdata;
          asm_d   = '0;
          cnt_d   = '0;
          case (mem_len)
            2'd0:    nbytes_d = 3'd1;
            2'd1:    nbytes_d = 3'd2;
            default: nbytes_d = 3'd4;
          endcase
          if (mem_we) begin
            state_d    = MEM_WR;
            ram_wr_d   = 1'b1;
            ram_dout_d = mem_wdata[7:0];
`ifdef MEM_ARB_IBUF_EN
            if (mem_addr[ADDR_W-1:2] == ib_tag_q[ADDR_W-1:2]) ib_valid_d = 1'b0;
`endif
          end else begin
            state_d = MEM_RD;
          end
        end else if (if_req && !if_flush) begin
`ifdef MEM_ARB_IBUF_EN
          if (ib_valid_q && (if_addr == ib_tag_q)) begin
            if_done_d = 1'b1;
            if_inst_d = ib_word_q;
          end else
`endif
          begin
            base_d   = if_addr;
            ram_a_d  = if_addr;
            nbytes_d = 3'd4;
            asm_d    = '0;
            cnt_d    = '0;
            state_d  = IF_RD;
          end
        end
      end
      IF_RD, MEM_RD: begin
        if ((state_q == IF_RD) && if_flush) begin
          state_d = IDLE;
          asm_d   = '0;
        end else begin
          cnt_d = nxt;
          if (nxt < nbytes_q) ram_a_d = base_q + ADDR_W'(nxt);
          if (cnt_q != 3'd0) asm_d[{cap_idx, 3'b000} +: 8] = ram_din;
          if (cnt_q == nbytes_q) begin
            state_d = IDLE;
            if (state_q == IF_RD) begin
              if_done_d = 1'b1;
              if_inst_d = asm_d;
`ifdef MEM_ARB_IBUF_EN
              ib_valid_d = 1'b1;
              ib_tag_d   = base_q;
              ib_word_d  = asm_d;
`endif
            end else begin
              mem_done_d  = 1'b1;
              mem_rdata_d = asm_d;
            end
          end
        end
      end
      MEM_WR: begin
        cnt_d = nxt;
        if (nxt < nbytes_q) begin
          ram_a_d    = base_q + ADDR_W'(nxt);
          ram_dout_d = wdata_q[{nxt[1:0], 3'b000} +: 8];
          ram_wr_d   = 1'b1;
        end else begin
          state_d    = IDLE;
          mem_done_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs; synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      base_q      <= '0;
      nbytes_q    <= '0;
      cnt_q       <= '0;
      wdata_q     <= '0;
      asm_q       <= '0;
      if_inst_q   <= '0;
      mem_rdata_q <= '0;
      if_done_q   <= 1'b0;
      mem_done_q  <= 1'b0;
      ram_a_q     <= '0;
      ram_dout_q  <= '0;
      ram_wr_q    <= 1'b0;
`ifdef MEM_ARB_IBUF_EN
      ib_valid_q  <= 1'b0;
      ib_tag_q    <= '0;
      ib_word_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      nbytes_q    <= nbytes_d;
      cnt_q       <= cnt_d;
      wdata_q     <= wdata_d;
      asm_q       <= asm_d;
      if_inst_q   <= if_inst_d;
      mem_rdata_q <= mem_rdata_d;
      if_done_q   <= if_done_d;
      mem_done_q  <= mem_done_d;
      ram_a_q     <= ram_a_d;
      ram_dout_q  <= ram_dout_d;
      ram_wr_q    <= ram_wr_d;
`ifdef MEM_ARB_IBUF_EN
      ib_valid_q  <= ib_valid_d;
      ib_tag_q    <= ib_tag_d;
      ib_word_q   <= ib_word_d;
`endif
    end
  end

  assign if_done   = if_done_q;
  assign if_inst   = if_inst_q;
  assign mem_done  = mem_done_q;
  assign mem_rdata = mem_rdata_q;
  assign ram_a     = ram_a_q;
  assign ram_dout  = ram_dout_q;
  assign ram_wr    = ram_wr_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed vectors for mem_arbiter with a behavioural byte RAM.
module tb_mem_arbiter;
  localparam int unsigned ADDR_W = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              if_req, if_flush, if_done;
  logic [ADDR_W-1:0] if_addr;
  logic [31:0]       if_inst;
  logic              mem_req, mem_we, mem_done;
  logic [1:0]        mem_len;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata, mem_rdata;
  logic [7:0]        ram_din, ram_dout;
  logic [ADDR_W-1:0] ram_a;
  logic              ram_wr, busy;

  logic [7:0]        ram [0:4095];
  int                n_cmp = 0;
  int                n_mis = 0;
  logic [ADDR_W-1:0] a_log    [0:31];
  logic              wr_log   [0:31];
  logic [7:0]        dout_log [0:31];
  logic              busy_log [0:31];
  int                if_cyc, mem_cyc, n_ifd, n_memd;

  mem_arbiter #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_done(if_done), .if_inst(if_inst),
    .mem_req(mem_req), .mem_we(mem_we), .mem_len(mem_len),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_done(mem_done), .mem_rdata(mem_rdata),
    .ram_din(ram_din), .ram_dout(ram_dout), .ram_a(ram_a),
    .ram_wr(ram_wr), .busy(busy)
  );

  always #5 clk = ~clk;

  // Synchronous byte RAM: read data appears the cycle after the address.
  always @(posedge clk) begin
    ram_din <= ram[ram_a[11:0]];
    if (ram_wr) ram[ram_a[11:0]] = ram_dout;
  end

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Current cycle is cycle 0; logs cycles 1..maxc, drops each request on its done.
  task automatic run(input int maxc, input bit want_if, input bit want_mem);
    if_cyc = -1; mem_cyc = -1; n_ifd = 0; n_memd = 0;
    for (int k = 1; k <= maxc; k++) begin
      tick();
      a_log[k] = ram_a; wr_log[k] = ram_wr; dout_log[k] = ram_dout; busy_log[k] = busy;
      if (mem_done) begin n_memd++; if (mem_cyc < 0) mem_cyc = k; mem_req = 1'b0; end
      if (if_done)  begin n_ifd++;  if (if_cyc < 0)  if_cyc = k;  if_req = 1'b0;  end
      if ((!want_if || if_cyc >= 0) && (!want_mem || mem_cyc >= 0)) break;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int bad;
    for (int i = 0; i < 4096; i++) ram[i] = 8'h00;
    ram[12'h100] = 8'h13; ram[12'h101] = 8'h05; ram[12'h102] = 8'hA0; ram[12'h103] = 8'h00;
    ram[12'h104] = 8'h93; ram[12'h105] = 8'h00; ram[12'h106] = 8'h10; ram[12'h107] = 8'h00;
    ram[12'h108] = 8'hB3; ram[12'h109] = 8'h05; ram[12'h10A] = 8'hB5; ram[12'h10B] = 8'h00;
    ram[12'h200] = 8'h34; ram[12'h201] = 8'h12;
    ram[12'h004] = 8'h5A;
    ram[12'hFFE] = 8'h11; ram[12'hFFF] = 8'h22; ram[12'h000] = 8'h33; ram[12'h001] = 8'h44;

    rst = 1'b1; if_req = 1'b0; if_addr = '0; if_flush = 1'b0;
    mem_req = 1'b0; mem_we = 1'b0; mem_len = 2'd0; mem_addr = '0; mem_wdata = '0;
    tick(); tick();
    chk_eq("rst_if_done",   32'(if_done),   32'd0);
    chk_eq("rst_mem_done",  32'(mem_done),  32'd0);
    chk_eq("rst_ram_wr",    32'(ram_wr),    32'd0);
    chk_eq("rst_ram_a",     ram_a,          32'd0);
    chk_eq("rst_ram_dout",  32'(ram_dout),  32'd0);
    chk_eq("rst_busy",      32'(busy),      32'd0);
    chk_eq("rst_if_inst",   if_inst,        32'd0);
    chk_eq("rst_mem_rdata", mem_rdata,      32'd0);
    rst = 1'b0;
    tick();

    // Word fetch at 0x100.
    if_addr = 32'h100; if_req = 1'b1;
    run(12, 1'b1, 1'b0);
    chk_eq("fetch_cycle", 32'(if_cyc), 32'd6);
    chk_eq("fetch_inst",  if_inst,     32'h00A00513);
    for (int i = 1; i <= 4; i++) chk_eq("fetch_ram_a", a_log[i], 32'h100 + 32'(i - 1));
    chk_eq("fetch_busy_c5", 32'(busy_log[5]), 32'd1);

    // Simultaneous: MEM half load wins, IF follows from the done cycle.
    mem_req = 1'b1; mem_we = 1'b0; mem_len = 2'd1; mem_addr = 32'h200;
    if_req = 1'b1; if_addr = 32'h108;
    run(16, 1'b1, 1'b1);
    chk_eq("prio_mem_cycle", 32'(mem_cyc), 32'd4);
    chk_eq("prio_rdata",     mem_rdata,    32'h00001234);
    chk_eq("prio_busy_c4",   32'(busy_log[4]), 32'd0);
    chk_eq("prio_if_ram_a",  a_log[5],     32'h108);
    chk_eq("prio_if_cycle",  32'(if_cyc),  32'd10);
    chk_eq("prio_if_inst",   if_inst,      32'h00B505B3);

    // Store byte at 0x3.
    mem_req = 1'b1; mem_we = 1'b1; mem_len = 2'd0; mem_addr = 32'h3; mem_wdata = 32'hDEADBEEF;
    run(8, 1'b0, 1'b1);
    chk_eq("sb_wr_c1",   32'(wr_log[1]),   32'd1);
    chk_eq("sb_dout_c1", 32'(dout_log[1]), 32'hEF);
    chk_eq("sb_a_c1",    a_log[1],         32'h3);
    chk_eq("sb_wr_c2",   32'(wr_log[2]),   32'd0);
    chk_eq("sb_done",    32'(mem_cyc),     32'd2);
    chk_eq("sb_ram3",    32'(ram[12'h003]), 32'hEF);
    chk_eq("sb_ram4",    32'(ram[12'h004]), 32'h5A);
    chk_eq("sb_rdata_hold", mem_rdata, 32'h00001234);
    chk_eq("sb_inst_hold",  if_inst,   32'h00B505B3);

    // Store half at 0x400.
    mem_req = 1'b1; mem_we = 1'b1; mem_len = 2'd1; mem_addr = 32'h400; mem_wdata = 32'h12345678;
    run(8, 1'b0, 1'b1);
    chk_eq("sh_done",    32'(mem_cyc),     32'd3);
    chk_eq("sh_a_c2",    a_log[2],         32'h401);
    chk_eq("sh_dout_c2", 32'(dout_log[2]), 32'h56);
    chk_eq("sh_wr_c3",   32'(wr_log[3]),   32'd0);
    chk_eq("sh_ram400",  32'(ram[12'h400]), 32'h78);
    chk_eq("sh_ram401",  32'(ram[12'h401]), 32'h56);
    chk_eq("sh_ram402",  32'(ram[12'h402]), 32'h00);

    // Word load (len=3) wrapping past the top of the address space.
    mem_req = 1'b1; mem_we = 1'b0; mem_len = 2'd3; mem_addr = 32'hFFFF_FFFE;
    run(12, 1'b0, 1'b1);
    chk_eq("wrap_done",  32'(mem_cyc), 32'd6);
    chk_eq("wrap_a_c3",  a_log[3],     32'h0);
    chk_eq("wrap_rdata", mem_rdata,    32'h44332211);

    // Flush in cycle 3 of a fetch, then a new fetch at 0x104.
    if_req = 1'b1; if_addr = 32'h100; bad = 0;
    for (int k = 1; k <= 3; k++) begin
      tick();
      if (if_done || ram_wr) bad++;
    end
    if_flush = 1'b1; if_addr = 32'h104;
    tick();
    if (if_done || ram_wr) bad++;
    chk_eq("flush_busy_c4", 32'(busy), 32'd0);
    chk_eq("flush_quiet",   32'(bad),  32'd0);
    if_flush = 1'b0;
    run(12, 1'b1, 1'b0);
    chk_eq("flush_refetch_cycle", 32'(if_cyc), 32'd6);
    chk_eq("flush_refetch_a",     a_log[1],    32'h104);
    chk_eq("flush_refetch_inst",  if_inst,     32'h00100093);

    // Reset in cycle 2 of a word store.
    mem_req = 1'b1; mem_we = 1'b1; mem_len = 2'd2; mem_addr = 32'h300; mem_wdata = 32'hCAFEF00D;
    tick(); tick();
    rst = 1'b1;
    tick();
    chk_eq("mrst_ram_wr",    32'(ram_wr),   32'd0);
    chk_eq("mrst_ram_a",     ram_a,         32'd0);
    chk_eq("mrst_ram_dout",  32'(ram_dout), 32'd0);
    chk_eq("mrst_busy",      32'(busy),     32'd0);
    chk_eq("mrst_mem_done",  32'(mem_done), 32'd0);
    chk_eq("mrst_if_inst",   if_inst,       32'd0);
    chk_eq("mrst_mem_rdata", mem_rdata,     32'd0);
    rst = 1'b0; mem_req = 1'b0; mem_we = 1'b0;
    tick();
    chk_eq("mrst_ram300", 32'(ram[12'h300]), 32'h0D);
    chk_eq("mrst_ram301", 32'(ram[12'h301]), 32'hF0);
    chk_eq("mrst_ram302", 32'(ram[12'h302]), 32'h00);

`ifdef MEM_ARB_IBUF_EN
    if_req = 1'b1; if_addr = 32'h100;
    run(12, 1'b1, 1'b0);
    chk_eq("ib_fill_cycle", 32'(if_cyc), 32'd6);
    if_req = 1'b1; if_addr = 32'h100;
    run(8, 1'b1, 1'b0);
    chk_eq("ib_hit_cycle", 32'(if_cyc),      32'd1);
    chk_eq("ib_hit_inst",  if_inst,          32'h00A00513);
    chk_eq("ib_hit_ram_a", a_log[1],         32'h103);
    chk_eq("ib_hit_busy",  32'(busy_log[1]), 32'd0);
    mem_req = 1'b1; mem_we = 1'b1; mem_len = 2'd0; mem_addr = 32'h102; mem_wdata = 32'h00000077;
    run(8, 1'b0, 1'b1);
    chk_eq("ib_store_done", 32'(mem_cyc), 32'd2);
    mem_we = 1'b0;
    if_req = 1'b1; if_addr = 32'h100;
    run(12, 1'b1, 1'b0);
    chk_eq("ib_inval_cycle", 32'(if_cyc), 32'd6);
    chk_eq("ib_inval_inst",  if_inst,     32'h00770513);
`else
    for (int r = 0; r < 2; r++) begin
      if_req = 1'b1; if_addr = 32'h100;
      run(12, 1'b1, 1'b0);
      chk_eq("refetch_cycle", 32'(if_cyc), 32'd6);
      chk_eq("refetch_inst",  if_inst,     32'h00A00513);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
